// File: rtl/pci_initiator_pkg.sv
// Shared PCI definitions: bus commands, completion status codes and initiator FSM states.
package pci_initiator_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam logic [1:0] STATUS_OK    = 2'b00;
  localparam logic [1:0] STATUS_STOP  = 2'b01;
  localparam logic [1:0] STATUS_ABORT = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StTurn,
    StAbort
  } state_e;

  function automatic logic [3:0] cmd_of(input logic write);
    return write ? CMD_MEM_WRITE : CMD_MEM_READ;
  endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// PCI control/handshake signals between an initiator and a target; AD_Line stays a separate inout.
interface pci_initiator_if;

  logic       Frame;
  logic [3:0] C_BE;
  logic       IRDY;
  logic       TRDY;
  logic       Dev_Sel;
  logic       s;

  modport master (output Frame, C_BE, IRDY, input TRDY, Dev_Sel, s);
  modport slave  (input Frame, C_BE, IRDY, output TRDY, Dev_Sel, s);

endinterface

// File: rtl/pci_initiator.sv
// PCI bus master: address phase, burst data phases, target stop, and master abort on DEVSEL timeout.
module pci_initiator
  import pci_initiator_pkg::*;
#(
  parameter int unsigned  MAX_BURST      = 4,
  parameter int unsigned  DEVSEL_TIMEOUT = 5,
  localparam int unsigned LenW           = $clog2(MAX_BURST + 1),
  localparam int unsigned ToW            = $clog2(DEVSEL_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            req_write,
  input  logic [31:0]     req_addr,
  input  logic [LenW-1:0] req_len,
  input  logic [31:0]     wr_data,
  input  logic [3:0]      wr_be,
  output logic            wr_pop,
  output logic [31:0]     rd_data,
  output logic            rd_valid,
  output logic            busy,
  output logic            done,
  output logic [1:0]      status,
  output logic [LenW-1:0] xfer_count,
  inout  wire  [31:0]     AD_Line,
  pci_initiator_if.master bus
);

  state_e          state_q, state_d;
  logic [LenW-1:0] count_q, count_d, len_q, len_in;
  logic [ToW-1:0]  to_q, to_d;
  logic            seen_q, seen_d;
  logic [1:0]      status_q, status_d;
  logic            ad_oe_q, ad_oe_d;
  logic [31:0]     addr_q, rd_data_q, ad_out;
  logic            write_q, rd_valid_q;
  logic            xfer, last;

  always_comb begin
    len_in = req_len;
    if (req_len == '0) begin
      len_in = LenW'(1);
    end else if (req_len > LenW'(MAX_BURST)) begin
      len_in = LenW'(MAX_BURST);
    end
  end

  assign xfer = (state_q == StData) && !bus.TRDY;
  assign last = (count_q == len_q - LenW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      to_q     <= '0;
      seen_q   <= 1'b0;
      status_q <= STATUS_OK;
      ad_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      to_q     <= to_d;
      seen_q   <= seen_d;
      status_q <= status_d;
      ad_oe_q  <= ad_oe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    to_d     = to_q;
    seen_d   = seen_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d  = StAddr;
          count_d  = '0;
          to_d     = '0;
          seen_d   = 1'b0;
          status_d = STATUS_OK;
        end
      end
      StAddr: state_d = StData;
      StData: begin
        if (!bus.Dev_Sel) seen_d = 1'b1;
        if (xfer && count_q != LenW'(MAX_BURST)) count_d = count_q + LenW'(1);
        // Completion beats a simultaneous stop.
        if (xfer && last) begin
          state_d  = StTurn;
          status_d = STATUS_OK;
        end else if (!bus.s) begin
          state_d  = StTurn;
          status_d = STATUS_STOP;
        end else if (!seen_q && bus.Dev_Sel) begin
          if (to_q == ToW'(DEVSEL_TIMEOUT - 1)) begin
            state_d  = StAbort;
            status_d = STATUS_ABORT;
            count_d  = '0;
          end else begin
            to_d = to_q + ToW'(1);
          end
        end
      end
      StAbort: state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ad_oe_d = (state_d == StAddr) || ((state_d == StData) && write_q);
  end

  always_comb begin
    bus.Frame = 1'b1;
    bus.IRDY  = 1'b1;
    bus.C_BE  = 4'b0000;
    ad_out    = wr_data;
    wr_pop    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StAddr: begin
        bus.Frame = 1'b0;
        bus.C_BE  = cmd_of(write_q);
        ad_out    = addr_q;
      end
      StData: begin
        bus.Frame = last;
        bus.IRDY  = 1'b0;
        bus.C_BE  = write_q ? wr_be : 4'b1111;
        wr_pop    = xfer && write_q;
      end
      StTurn:  done = 1'b1;
      default: ;
    endcase
  end

  assign AD_Line = ad_oe_q ? ad_out : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      len_q      <= LenW'(1);
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (state_q == StIdle && req) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        len_q   <= len_in;
      end
      rd_valid_q <= xfer && !write_q;
      if (xfer && !write_q) rd_data_q <= AD_Line;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q != StIdle);
  assign status     = status_q;
  assign xfer_count = count_q;

endmodule
